// File: rtl/mips_pkg.sv
// Shared constants and pipeline payload types for the MEM/WB slice of the
// MIPS pipeline. Optional misaligned-access detection is enabled with the
// macro MEM_ALIGN_CHK_EN (adds the excp field to the MEM/WB payload).
package mips_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_W     = 5;
  localparam int DM_ADDR_W = 10;

  // Control bits that travel with an instruction from EX into MEM.
  typedef struct packed {
    logic gprWr;
    logic dmWr;
    logic mtr;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{gprWr: 1'b0, dmWr: 1'b0, mtr: 1'b0};

  // EX/MEM register payload.
  typedef struct packed {
    ctrl_t              ctrl;
    logic [DATA_W-1:0]  busC;
    logic [DATA_W-1:0]  busB;
    logic [REG_W-1:0]   rd;
  } exmem_t;

  localparam exmem_t EXMEM_BUBBLE = '{ctrl: CTRL_BUBBLE, default: '0};

  // MEM/WB register payload.
  typedef struct packed {
    logic               gprWr;
    logic               mtr;
    logic [DATA_W-1:0]  rdata;
    logic [DATA_W-1:0]  aluRes;
    logic [REG_W-1:0]   rd;
`ifdef MEM_ALIGN_CHK_EN
    logic               excp;
`endif
  } memwb_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bus bundle between the EX stage, the MEM/WB stage and writeback.
// With MEM_ALIGN_CHK_EN defined the bundle also carries o_excp.
interface mem_wb_stage_if #(parameter int DW = 32);

  logic          i_flush;
  logic [DW-1:0] i_busC;
  logic [DW-1:0] i_busB;
  logic [4:0]    i_rd;
  logic          i_GPRWr;
  logic          i_DMWr;
  logic          i_MTR;

  logic [DW-1:0] o_busW;
  logic [4:0]    o_rw;
  logic          o_GPRWr;
  logic [4:0]    o_fwd_rd;
  logic          o_fwd_GPRWr;
  logic [DW-1:0] o_fwd_data;

`ifdef MEM_ALIGN_CHK_EN
  logic          o_excp;

  modport master (
    output i_flush, i_busC, i_busB, i_rd, i_GPRWr, i_DMWr, i_MTR,
    input  o_busW, o_rw, o_GPRWr, o_fwd_rd, o_fwd_GPRWr, o_fwd_data, o_excp
  );

  modport slave (
    input  i_flush, i_busC, i_busB, i_rd, i_GPRWr, i_DMWr, i_MTR,
    output o_busW, o_rw, o_GPRWr, o_fwd_rd, o_fwd_GPRWr, o_fwd_data, o_excp
  );
`else
  modport master (
    output i_flush, i_busC, i_busB, i_rd, i_GPRWr, i_DMWr, i_MTR,
    input  o_busW, o_rw, o_GPRWr, o_fwd_rd, o_fwd_GPRWr, o_fwd_data
  );

  modport slave (
    input  i_flush, i_busC, i_busB, i_rd, i_GPRWr, i_DMWr, i_MTR,
    output o_busW, o_rw, o_GPRWr, o_fwd_rd, o_fwd_GPRWr, o_fwd_data
  );
`endif

endinterface

// File: rtl/dm_4k.sv
// 4 KB word-addressed data memory: combinational read, synchronous write,
// contents untouched by reset.
module dm_4k #(
  parameter int DW    = 32,
  parameter int DM_AW = 10
) (
  input  logic             clk,
  input  logic             DMWr,
  input  logic [DM_AW-1:0] addr,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout
);

  logic [DW-1:0] r_mem [0:(1<<DM_AW)-1];

  // Store commits at the rising edge; a load in the following cycle sees it.
  always_ff @(posedge clk) begin
    if (DMWr) begin
      r_mem[addr] <= din;
    end
  end

  assign dout = r_mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: EX/MEM register, data memory and MEM/WB register feeding
// the GPR writeback port, plus EX/MEM forwarding taps.
// Optional macro MEM_ALIGN_CHK_EN: misaligned loads/stores are suppressed
// and flagged on o_excp in the MEM/WB slot of the faulting instruction.
// DW must equal mips_pkg::DATA_W since the payload structs use that width.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DW    = DATA_W,
  parameter int DM_AW = DM_ADDR_W
) (
  input  logic            clk,
  input  logic            clr,
  mem_wb_stage_if.slave   bus
);

  exmem_t             r_exMem;
  memwb_t             r_memWb;
  logic [DM_AW-1:0]   w_addr;
  logic [DW-1:0]      w_rdata;
  logic               w_rdNz;
  logic               w_misal;
  logic               w_dmWr;

  assign w_addr = r_exMem.busC[DM_AW+1:2];
  assign w_rdNz = (r_exMem.rd != '0);

`ifdef MEM_ALIGN_CHK_EN
  assign w_misal = (r_exMem.busC[1:0] != 2'b00) && (r_exMem.ctrl.dmWr || r_exMem.ctrl.mtr);
`else
  assign w_misal = 1'b0;
`endif

  assign w_dmWr = r_exMem.ctrl.dmWr && !w_misal;

  // EX/MEM register: capture the EX results, or a bubble when flushed.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_exMem <= '0;
    end else if (bus.i_flush) begin
      r_exMem <= EXMEM_BUBBLE;
    end else begin
      r_exMem <= '{ctrl:   '{gprWr: bus.i_GPRWr, dmWr: bus.i_DMWr, mtr: bus.i_MTR},
                   busC:   bus.i_busC,
                   busB:   bus.i_busB,
                   rd:     bus.i_rd};
    end
  end

  dm_4k #(.DW(DW), .DM_AW(DM_AW)) u_dm (
    .clk  (clk),
    .DMWr (w_dmWr),
    .addr (w_addr),
    .din  (r_exMem.busB),
    .dout (w_rdata)
  );

  // MEM/WB register: latch load data and ALU result; writes to r0 or from a
  // faulting access never reach the register file.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_memWb <= '0;
    end else begin
      r_memWb.gprWr  <= r_exMem.ctrl.gprWr && w_rdNz && !w_misal;
      r_memWb.mtr    <= r_exMem.ctrl.mtr;
      r_memWb.rdata  <= w_rdata;
      r_memWb.aluRes <= r_exMem.busC;
      r_memWb.rd     <= r_exMem.rd;
`ifdef MEM_ALIGN_CHK_EN
      r_memWb.excp   <= w_misal;
`endif
    end
  end

  assign bus.o_busW      = r_memWb.mtr ? r_memWb.rdata : r_memWb.aluRes;
  assign bus.o_rw        = r_memWb.rd;
  assign bus.o_GPRWr     = r_memWb.gprWr;
  assign bus.o_fwd_rd    = r_exMem.rd;
  assign bus.o_fwd_GPRWr = r_exMem.ctrl.gprWr && w_rdNz;
  assign bus.o_fwd_data  = r_exMem.busC;
`ifdef MEM_ALIGN_CHK_EN
  assign bus.o_excp      = r_memWb.excp;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed plan steps followed by a
// randomized instruction stream, all checked against an instruction-level
// reference model. Honours MEM_ALIGN_CHK_EN when defined.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.DW(32)) bus();

  mem_wb_stage #(.DW(32), .DM_AW(10)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] busC;
    logic [31:0] busB;
    logic [4:0]  rd;
    bit          gpr;
    bit          dmw;
    bit          mtr;
  } instr_t;

  // Reference model: memory as a plain word array, the instruction sitting
  // in MEM, and the writeback result it produced last.
  logic [31:0] refMem [1024];
  instr_t      mEx;
  logic [31:0] eBusW;
  logic [4:0]  eRw;
  bit          eGpr;
  bit          eExcp;

  int nChecks = 0;
  int nPass   = 0;

  function automatic bit isMisaligned(instr_t x);
`ifdef MEM_ALIGN_CHK_EN
    return ((x.busC % 4) != 0) && (x.dmw || x.mtr);
`else
    return 1'b0;
`endif
  endfunction

  function automatic instr_t emptyInstr();
    instr_t x;
    x.busC = '0; x.busB = '0; x.rd = '0; x.gpr = 0; x.dmw = 0; x.mtr = 0;
    return x;
  endfunction

  task automatic modelReset();
    mEx   = emptyInstr();
    eBusW = '0;
    eRw   = '0;
    eGpr  = 0;
    eExcp = 0;
  endtask

  // One clock edge: the instruction in MEM retires into writeback (reading
  // memory before its own store), and the newly presented one enters MEM.
  task automatic modelEdge(instr_t nxt, bit flush);
    int          w;
    logic [31:0] rdat;
    bit          bad;
    w     = int'((mEx.busC / 4) % 1024);
    rdat  = refMem[w];
    bad   = isMisaligned(mEx);
    eBusW = mEx.mtr ? rdat : mEx.busC;
    eRw   = mEx.rd;
    eGpr  = mEx.gpr && (mEx.rd != 0) && !bad;
    eExcp = bad;
    if (mEx.dmw && !bad) refMem[w] = mEx.busB;
    mEx = flush ? emptyInstr() : nxt;
  endtask

  task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic checkOutput();
    checkVal("busW",     bus.o_busW,                    eBusW);
    checkVal("rw",       {27'b0, bus.o_rw},             {27'b0, eRw});
    checkVal("GPRWr",    {31'b0, bus.o_GPRWr},          {31'b0, eGpr});
    checkVal("fwdRd",    {27'b0, bus.o_fwd_rd},         {27'b0, mEx.rd});
    checkVal("fwdGPRWr", {31'b0, bus.o_fwd_GPRWr},      {31'b0, (mEx.gpr && mEx.rd != 0)});
    checkVal("fwdData",  bus.o_fwd_data,                mEx.busC);
`ifdef MEM_ALIGN_CHK_EN
    checkVal("excp",     {31'b0, bus.o_excp},           {31'b0, eExcp});
`endif
  endtask

  // Present one instruction at the falling edge, clock it in, check outputs
  // at the next falling edge.
  task automatic applyStimulus(logic [31:0] busC, logic [31:0] busB, logic [4:0] rd,
                               bit gpr, bit dmw, bit mtr, bit flush);
    instr_t x;
    bus.i_busC  = busC;
    bus.i_busB  = busB;
    bus.i_rd    = rd;
    bus.i_GPRWr = gpr;
    bus.i_DMWr  = dmw;
    bus.i_MTR   = mtr;
    bus.i_flush = flush;
    x.busC = busC; x.busB = busB; x.rd = rd; x.gpr = gpr; x.dmw = dmw; x.mtr = mtr;
    @(posedge clk);
    modelEdge(x, flush);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic nop();
    applyStimulus(32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] bases [4];
    logic [31:0] addr;
    int          op;
    bases[0] = 32'h10; bases[1] = 32'h20; bases[2] = 32'h40; bases[3] = 32'h80;

    clr = 1'b0;
    bus.i_flush = 0; bus.i_busC = '0; bus.i_busB = '0; bus.i_rd = '0;
    bus.i_GPRWr = 0; bus.i_DMWr = 0; bus.i_MTR = 0;
    modelReset();
    @(negedge clk);
    checkOutput();
    clr = 1'b1;

    // Mid-run reset with a store pending: the store must not commit.
    applyStimulus(32'h40, 32'hA1A1A1A1, 5'd0, 0, 1, 0, 0);
    applyStimulus(32'h40, 32'hB2B2B2B2, 5'd0, 0, 1, 0, 0);
    #2 clr = 1'b0;
    modelReset();
    #1 checkOutput();
    checkVal("resetBusW", bus.o_fwd_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    applyStimulus(32'h40, 32'h0, 5'd4, 1, 0, 1, 0);
    nop();
    checkVal("resetNoStore", bus.o_busW, 32'hA1A1A1A1);

    // Store then load to the same word.
    applyStimulus(32'h10, 32'hDEADBEEF, 5'd0, 0, 1, 0, 0);
    applyStimulus(32'h10, 32'h0, 5'd8, 1, 0, 1, 0);
    nop();
    checkVal("lwData", bus.o_busW, 32'hDEADBEEF);
    checkVal("lwRw", {27'b0, bus.o_rw}, 32'd8);
    checkVal("lwGPRWr", {31'b0, bus.o_GPRWr}, 32'd1);

    // ALU writeback and forwarding tap.
    applyStimulus(32'h1234, 32'h0, 5'd3, 1, 0, 0, 0);
    checkVal("fwd1234", bus.o_fwd_data, 32'h1234);
    nop();
    checkVal("alu1234", bus.o_busW, 32'h1234);
    checkVal("aluRw", {27'b0, bus.o_rw}, 32'd3);

    // Write to r0 is suppressed.
    applyStimulus(32'h77, 32'h0, 5'd0, 1, 0, 0, 0);
    checkVal("rd0Fwd", {31'b0, bus.o_fwd_GPRWr}, 32'd0);
    nop();
    checkVal("rd0Wb", {31'b0, bus.o_GPRWr}, 32'd0);

    // Flushed store leaves memory alone.
    applyStimulus(32'h20, 32'h11, 5'd0, 0, 1, 0, 0);
    applyStimulus(32'h20, 32'h55, 5'd0, 0, 1, 0, 1);
    nop();
    checkVal("flushWb", {31'b0, bus.o_GPRWr}, 32'd0);
    applyStimulus(32'h20, 32'h0, 5'd5, 1, 0, 1, 0);
    nop();
    checkVal("flushMem", bus.o_busW, 32'h11);

    // Address wrap modulo 4 KB.
    applyStimulus(32'h1010, 32'hCAFEF00D, 5'd0, 0, 1, 0, 0);
    applyStimulus(32'h0010, 32'h0, 5'd6, 1, 0, 1, 0);
    nop();
    checkVal("wrap", bus.o_busW, 32'hCAFEF00D);

`ifdef MEM_ALIGN_CHK_EN
    applyStimulus(32'h0012, 32'h0, 5'd9, 1, 0, 1, 0);
    nop();
    checkVal("misalExcp", {31'b0, bus.o_excp}, 32'd1);
    checkVal("misalGPRWr", {31'b0, bus.o_GPRWr}, 32'd0);
    nop();
    checkVal("misalPulse", {31'b0, bus.o_excp}, 32'd0);
`endif

    // Initialise the last random-phase word, then a random instruction mix.
    applyStimulus(32'h80, 32'h80808080, 5'd0, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      op   = int'($urandom_range(0, 2));
      addr = bases[$urandom_range(0, 3)] + 32'h1000 * $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) addr = addr + $urandom_range(1, 3);
      case (op)
        0: applyStimulus($urandom, $urandom, 5'($urandom_range(0, 31)),
                         1'($urandom_range(0, 1)), 0, 0, $urandom_range(0, 9) == 0);
        1: applyStimulus(addr, $urandom, 5'($urandom_range(0, 31)),
                         1'($urandom_range(0, 1)), 1, 0, $urandom_range(0, 9) == 0);
        default: applyStimulus(addr, $urandom, 5'($urandom_range(0, 31)),
                         1'($urandom_range(0, 1)), 0, 1, $urandom_range(0, 9) == 0);
      endcase
    end
    nop();
    nop();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
